// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the MEM/WB bundle and
// small decode helpers used by the memory stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] R0_IDX = '0;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              zero;
  } memwb_t;

  // A memory op whose byte address is not word aligned.
  function automatic logic is_unaligned(input logic rd, input logic wr,
                                        input logic [1:0] lo);
    return (rd | wr) && (lo != 2'b00);
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM: synchronous write, registered read, no array reset.
module data_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word lw/sw against data_ram and the MEM/WB
// pipeline register feeding register-file writeback.
module mem_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = 8,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write,
  output logic              wb_zero,
  output logic              misaligned,
  output logic              misalign_sticky
);

  import mips_pkg::*;

  logic              accept_p0;
  logic              unaligned_p0;
  logic              is_store_p0;
  logic              is_load_p0;
  logic              ram_we_p0;
  logic              ram_re_p0;
  logic [ADDR_W-1:0] idx_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] pass_p1;
  logic              load_sel_p1;
  logic [REG_W-1:0]  rd_p1;
  logic              reg_write_p1;
  logic              zero_p1;
  logic              mis_p1;
  logic              sticky_p1;
  logic [DATA_W-1:0] ram_q_p1;

  // p0: decode the EX/MEM slot; both-high read/write resolves to a store
  always_comb begin
    accept_p0    = !rst && !stall && !flush && in_valid;
    unaligned_p0 = is_unaligned(mem_read, mem_write, alu_result[1:0]);
    is_store_p0  = mem_write && !unaligned_p0;
    is_load_p0   = mem_read && !mem_write && !unaligned_p0;
    ram_we_p0    = accept_p0 && is_store_p0;
    ram_re_p0    = accept_p0 && is_load_p0;
    idx_p0       = alu_result[ADDR_W+1:2];
  end

  data_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_p0),
    .re   (ram_re_p0),
    .addr (idx_p0),
    .wdata(store_data),
    .rdata(ram_q_p1)
  );

  // p1: MEM/WB register; ram_q_p1 only moves on an accepted load, so it
  // holds together with the rest of the slot through stalls and bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pass_p1      <= '0;
      load_sel_p1  <= 1'b0;
      rd_p1        <= '0;
      reg_write_p1 <= 1'b0;
      zero_p1      <= 1'b0;
      mis_p1       <= 1'b0;
      sticky_p1    <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mis_p1       <= 1'b0;
    end else if (stall) begin
      mis_p1       <= 1'b0;
    end else begin
      vld_p1       <= 1'b1;
      pass_p1      <= alu_result;
      load_sel_p1  <= is_load_p0;
      rd_p1        <= rd_in;
      zero_p1      <= alu_zero;
      reg_write_p1 <= reg_write_in && !mem_write && !unaligned_p0;
      mis_p1       <= unaligned_p0;
      if (unaligned_p0) sticky_p1 <= 1'b1;
    end
  end

  always_comb begin
    wb_valid        = vld_p1;
    wb_data         = load_sel_p1 ? ram_q_p1 : pass_p1;
    wb_rd           = rd_p1;
    wb_reg_write    = reg_write_p1;
    wb_zero         = zero_p1;
    misaligned      = mis_p1;
    misalign_sticky = sticky_p1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic checked
// against a word-array reference model of the stage.
module tb_mem_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] store_data;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write_in;
  logic [REG_W-1:0]  rd_in;
  logic              stall;
  logic              flush;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_reg_write;
  logic              wb_zero;
  logic              misaligned;
  logic              misalign_sticky;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              e_valid, e_rw, e_zero, e_mis, e_sticky;
  logic [DATA_W-1:0] e_data;
  logic [REG_W-1:0]  e_rd;

  mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .alu_zero(alu_zero), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_zero(wb_zero),
    .misaligned(misaligned), .misalign_sticky(misalign_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the stage rules, compare.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] a,
                      input logic z, input logic [DATA_W-1:0] sd,
                      input logic mr, input logic mw, input logic rwi,
                      input logic [REG_W-1:0] rd, input logic st, input logic fl);
    int idx;
    logic unal;
    @(negedge clk);
    rst = r; in_valid = v; alu_result = a; alu_zero = z; store_data = sd;
    mem_read = mr; mem_write = mw; reg_write_in = rwi; rd_in = rd;
    stall = st; flush = fl;
    idx  = int'((a / 4) % DEPTH);
    unal = (mr || mw) && (a % 4 != 0);
    if (r) begin
      {e_valid, e_rw, e_zero, e_mis, e_sticky} = '0;
      e_data = '0; e_rd = '0;
    end else if (fl || (!st && !v)) begin
      e_valid = 0; e_rw = 0; e_mis = 0;
    end else if (st) begin
      e_mis = 0;
    end else begin
      e_valid = 1; e_rd = rd; e_zero = z; e_mis = unal;
      if (unal) begin
        e_sticky = 1; e_rw = 0; e_data = a;
      end else if (mw) begin
        ref_mem[idx] = sd; e_rw = 0; e_data = a;
      end else if (mr) begin
        e_data = ref_mem[idx]; e_rw = rwi;
      end else begin
        e_data = a; e_rw = rwi;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", DATA_W'(wb_valid), DATA_W'(e_valid));
    chk("wb_data", wb_data, e_data);
    chk("wb_rd", DATA_W'(wb_rd), DATA_W'(e_rd));
    chk("wb_reg_write", DATA_W'(wb_reg_write), DATA_W'(e_rw));
    chk("wb_zero", DATA_W'(wb_zero), DATA_W'(e_zero));
    chk("misaligned", DATA_W'(misaligned), DATA_W'(e_mis));
    chk("misalign_sticky", DATA_W'(misalign_sticky), DATA_W'(e_sticky));
  endtask

  task automatic sw(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    step(0, 1, a, 0, d, 0, 1, 0, 5'd0, 0, 0);
  endtask

  task automatic lw(input logic [DATA_W-1:0] a, input logic [REG_W-1:0] rd);
    step(0, 1, a, 0, 32'h0, 1, 0, 1, rd, 0, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] a, d;
    int op;
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 5'd0, 0, 0);
    step(1, 1, 32'h0, 1, 32'hFFFF_FFFF, 1, 0, 1, 5'd9, 0, 0);

    // Fill RAM so every later load has a known expected word
    for (int i = 0; i < DEPTH; i++) sw(DATA_W'(i * 4), $urandom);

    // Store then load same word
    sw(32'h10, 32'hDEADBEEF);
    lw(32'h10, 5'd8);
    chk("tp1_data", wb_data, 32'hDEADBEEF);
    chk("tp1_rd", DATA_W'(wb_rd), 32'd8);

    // Pass-through and zero flag
    step(0, 1, 32'h12340000, 0, 32'h0, 0, 0, 1, 5'd3, 0, 0);
    chk("tp2_data", wb_data, 32'h12340000);
    step(0, 1, 32'h0, 1, 32'h0, 0, 0, 1, 5'd3, 0, 0);
    chk("tp2_zero", DATA_W'(wb_zero), 32'd1);

    // Misaligned store: pulse, sticky, no RAM write
    sw(32'h20, 32'h1111_2222);
    sw(32'h22, 32'h55);
    chk("tp3_mis", DATA_W'(misaligned), 32'd1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 5'd0, 0, 0);
    lw(32'h20, 5'd4);
    chk("tp3_old_word", wb_data, 32'h1111_2222);
    chk("tp3_sticky", DATA_W'(misalign_sticky), 32'd1);

    // Stall three cycles over a store, then release and read back
    lw(32'h44, 5'd6);
    repeat (3) step(0, 1, 32'h40, 0, 32'hA5A5A5A5, 0, 1, 0, 5'd0, 1, 0);
    sw(32'h40, 32'hA5A5A5A5);
    lw(32'h40, 5'd7);
    chk("tp4_data", wb_data, 32'hA5A5A5A5);

    // Flush with stall kills a valid store
    sw(32'h8, 32'h0BAD_F00D);
    step(0, 1, 32'h8, 0, 32'hCAFE_0000, 0, 1, 0, 5'd0, 1, 1);
    lw(32'h8, 5'd2);
    chk("tp5_ram2", wb_data, 32'h0BAD_F00D);

    // Aliasing, both-high treated as store, store dropped in reset cycle
    sw(32'h404, 32'h0404_0404);
    lw(32'h004, 5'd1);
    chk("tp6_alias", wb_data, 32'h0404_0404);
    step(0, 1, 32'h30, 0, 32'h3030_3030, 1, 1, 1, 5'd12, 0, 0);
    step(1, 1, 32'h30, 0, 32'h9999_9999, 0, 1, 0, 5'd0, 0, 0);
    lw(32'h30, 5'd12);
    chk("tp6_rst_store", wb_data, 32'h3030_3030);

    // Randomized traffic over a small window to force address reuse
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 99));
      a  = {$urandom_range(0, 15) == 0 ? 22'($urandom) : 22'h0,
            ADDR_W'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0 ? 2'($urandom) : 2'b00};
      d  = $urandom;
      step(op == 0, $urandom_range(0, 7) != 0, a, 1'($urandom), d,
           op < 45, (op >= 40 && op < 75), 1'($urandom), 5'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the ALU.
- Consumes the ALU result as a load/store byte address or as a pass-through result, plus the ALU zero flag.
- Performs word loads and stores against an internal synchronous data RAM.
- Registers the MEM/WB pipeline outputs that feed register-file writeback.

Parameters:
- DATA_W, 32, datapath width; must match the ALU result width.
- ADDR_W, 8, word-index width; RAM depth = 2**ADDR_W words.
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  EX/MEM slot holds a real instruction.
- alu_result  input  DATA_W  ALU output: byte address for lw/sw, otherwise the writeback value.
- alu_zero  input  1  ALU zero flag; passed through.
- store_data  input  DATA_W  rt value for sw.
- mem_read  input  1  instruction is lw.
- mem_write  input  1  instruction is sw.
- reg_write_in  input  1  instruction writes the register file.
- rd_in  input  REG_W  destination register.
- stall  input  1  hold this stage.
- flush  input  1  kill the instruction currently presented.
- wb_valid  output  1  MEM/WB slot valid.
- wb_data  output  DATA_W  load data or pass-through ALU result.
- wb_rd  output  REG_W  destination register.
- wb_reg_write  output  1  writeback enable.
- wb_zero  output  1  registered alu_zero.
- misaligned  output  1  one-cycle pulse: the instruction just captured was an unaligned lw/sw.
- misalign_sticky  output  1  set by any misaligned access; cleared only by rst.

Behaviour:
- All state changes on the rising edge of clk. rst is sampled synchronously and has top priority.
- Reset: wb_valid, wb_data, wb_rd, wb_reg_write, wb_zero, misaligned and misalign_sticky all go to 0.
  - Any store presented in the reset cycle is suppressed.
  - RAM contents are not reset.
- Address: word index = alu_result[ADDR_W+1:2].
  - Bits above ADDR_W+1 are ignored, so addresses alias modulo 2**(ADDR_W+2).
  - Unaligned access = (mem_read | mem_write) with alu_result[1:0] != 0.
- Stage "accepts" in a cycle when rst=0, stall=0, flush=0 and in_valid=1.
- Priority per cycle: rst > flush > stall > normal.
- Flush:
  - MEM/WB outputs become a bubble: wb_valid=0, wb_reg_write=0, misaligned=0. wb_data, wb_rd and wb_zero hold.
  - No RAM write occurs.
  - misalign_sticky holds.
- Stall:
  - All outputs hold their previous values; misaligned is cleared to 0 so the pulse never repeats.
  - No RAM write occurs.
- Normal, in_valid=0: bubble, same as flush.
- Normal, in_valid=1:
  - wb_valid=1, wb_rd=rd_in, wb_zero=alu_zero.
  - Store (mem_write=1, aligned): RAM[idx] <= store_data. wb_reg_write=0; wb_data=alu_result.
  - Load (mem_read=1, aligned): wb_data = RAM[idx] (synchronous read, 1-cycle latency). wb_reg_write=reg_write_in.
  - Neither: wb_data=alu_result, wb_reg_write=reg_write_in.
  - Unaligned lw/sw: no RAM write, wb_reg_write=0, wb_data=alu_result, misaligned=1, misalign_sticky=1.
  - mem_read and mem_write both high is illegal. Required response: treat as a store, wb_reg_write=0.
- Latency: exactly 1 cycle from acceptance to the MEM/WB outputs.
- Back-to-back sw then lw to the same word: the lw, accepted on the next edge, returns the newly stored data. No stale read.
- Only one instruction occupies the stage, so a same-cycle read/write collision cannot occur.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_W constants.
  - a MEM/WB bundle typedef: valid, data, rd, reg_write, zero.
  - the register index of r0.
- One sub-module: data_ram.
  - Single port, 2**ADDR_W x DATA_W.
  - Synchronous write enable, synchronous registered read.
  - No reset on the array.
- Stage control logic and the MEM/WB registers live in mem_stage.

Test Plan:
1. Reset, then sw with alu_result=0x10, store_data=0xDEADBEEF; next cycle lw alu_result=0x10, rd_in=8, reg_write_in=1 -> one cycle after lw acceptance: wb_data=0xDEADBEEF, wb_rd=8, wb_reg_write=1, wb_valid=1.
2. Pass-through: alu_result=0x12340000, rd_in=3, reg_write_in=1, alu_zero=0 -> next cycle wb_data=0x12340000, wb_reg_write=1, wb_zero=0. Repeat with alu_result=0, alu_zero=1 -> wb_zero=1.
3. Misaligned sw at 0x22 with store_data=0x55 -> misaligned pulses for one cycle, misalign_sticky=1 until rst, wb_reg_write=0. A subsequent aligned lw 0x20 returns the prior word, not 0x55.
4. Stall held for 3 cycles during a sw to 0x40 with store_data=0xA5A5A5A5 -> no RAM write and outputs frozen. On release, the write commits; a later lw 0x40 returns 0xA5A5A5A5.
5. flush and stall both asserted with a valid sw to 0x8 -> bubble (wb_valid=0, wb_reg_write=0), RAM[2] unchanged.
6. Aliasing and reset: sw 0x404 with ADDR_W=8, then lw 0x004 -> same word returned. Asserting rst in the same cycle as a sw -> that store is dropped and all outputs are 0 on the next cycle.
